// File: rtl/dma_addr_gen_pkg.sv
// dma_pkg: shared encodings, address map, instruction fields and FSM states for the DMA address generator
package dma_pkg;
  localparam int ADDR_W = 8;
  localparam int CNT_W = 6;
  localparam int INSTR_W = 26;
  localparam int MEM_TOP = 191;
  localparam int IO1_BASE = 192;
  localparam int IO2_BASE = 224;
  localparam int FE_BASE = 128;
  localparam int FE_TOP = 191;
  localparam logic [1:0] OP_IO2MEM = 2'b00;
  localparam logic [1:0] OP_MEM2X = 2'b01;
  localparam logic [1:0] TY_IO = 2'b01;
  localparam logic [1:0] TY_MEM = 2'b10;
  localparam int OP_LSB = 24;
  localparam int TY_LSB = 22;
  localparam int SRC_LSB = 14;
  localparam int DST_LSB = 6;
  localparam int CNT_LSB = 0;
  typedef enum logic [1:0] {IDLE, REQ, XFER, DONE} state_e;
endpackage

// File: rtl/dma_addr_gen_if.sv
// dma_addr_gen_if: instruction, bus-arbitration and address signals between DMA front end and its neighbours
interface dma_addr_gen_if import dma_pkg::*; #(parameter int AW = ADDR_W);
  logic instr_valid;
  logic [INSTR_W-1:0] instr;
  logic instr_ready;
  logic [INSTR_W-1:0] DMA_instruction;
  logic bus_req;
  logic grant;
  logic IOIP1;
  logic IOIP2;
  logic [AW-1:0] next_source;
  logic [AW-1:0] next_destination;
  logic [AW-1:0] firstempty;
  logic done;
  logic busy;
  modport master(output instr_valid, instr, grant, IOIP1, IOIP2,
                 input instr_ready, DMA_instruction, bus_req, next_source, next_destination, firstempty, done, busy);
  modport slave(input instr_valid, instr, grant, IOIP1, IOIP2,
                output instr_ready, DMA_instruction, bus_req, next_source, next_destination, firstempty, done, busy);
endinterface

// File: rtl/dma_addr_gen_wrap_ptr.sv
// dma_wrap_ptr: loadable up-counter that wraps from HI back to LO
module dma_wrap_ptr #(
  parameter int W = 8,
  parameter int LO = 0,
  parameter int HI = 255,
  parameter int RST = 0
) (
  input  logic clock,
  input  logic rst_n,
  input  logic ld_i,
  input  logic en_i,
  input  logic [W-1:0] val_i,
  output logic [W-1:0] ptr_o
);
  logic [W-1:0] ptr_q, ptr_d;
  always_comb ptr_d = ld_i ? val_i : en_i ? (ptr_q == W'(HI) ? W'(LO) : ptr_q + 1'b1) : ptr_q;
  always_ff @(posedge clock or negedge rst_n)
    if (!rst_n) ptr_q <= W'(RST);
    else ptr_q <= ptr_d;
  assign ptr_o = ptr_q;
endmodule

// File: rtl/dma_addr_gen.sv
// dma_addr_gen: latches one DMA instruction, arbitrates for the bus and steps source/destination per beat
module dma_addr_gen #(
  parameter int ADDR_W = dma_pkg::ADDR_W,
  parameter int CNT_W = dma_pkg::CNT_W,
  parameter int MEM_TOP = dma_pkg::MEM_TOP,
  parameter int FE_BASE = dma_pkg::FE_BASE,
  parameter int FE_TOP = dma_pkg::FE_TOP
) (
  input logic clock,
  input logic rst_n,
  dma_addr_gen_if.slave bus
);
  import dma_pkg::*;
  state_e state_q, state_d;
  logic [CNT_W-1:0] rem_q, rem_d, cnt;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic accept, beat, step_src, step_dst, fe_step;
  assign cnt = bus.instr[CNT_LSB +: CNT_W];
  assign accept = state_q == IDLE && bus.instr_valid;
  assign beat = state_q == XFER && bus.grant;
  // I/O ports sit above MEM_TOP and must not move, whatever the transfer type
  assign step_src = beat && bus.next_source <= ADDR_W'(MEM_TOP);
  assign step_dst = beat && bus.next_destination <= ADDR_W'(MEM_TOP);
  assign fe_step = state_q == IDLE && bus.grant && (bus.IOIP1 || bus.IOIP2);
  always_comb begin
    state_d = state_q;
    rem_d = rem_q;
    instr_d = instr_q;
    state_d = state_q == IDLE ? (accept ? (cnt == '0 ? DONE : REQ) : IDLE)
            : state_q == REQ  ? (bus.grant ? XFER : REQ)
            : state_q == XFER ? (!bus.grant ? REQ : rem_q == CNT_W'(1) ? DONE : XFER)
            : IDLE;
    rem_d = accept ? cnt : beat ? rem_q - 1'b1 : rem_q;
    instr_d = accept ? bus.instr : instr_q;
  end
  always_ff @(posedge clock or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      rem_q <= '0;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      rem_q <= rem_d;
      instr_q <= instr_d;
    end
  assign bus.instr_ready = state_q == IDLE;
  assign bus.bus_req = state_q == REQ || state_q == XFER;
  assign bus.done = state_q == DONE;
  assign bus.busy = state_q != IDLE;
  assign bus.DMA_instruction = instr_q;
  dma_wrap_ptr #(.W(ADDR_W), .LO(0), .HI(MEM_TOP), .RST(0)) u_src (
    .clock(clock), .rst_n(rst_n), .ld_i(accept), .en_i(step_src),
    .val_i(bus.instr[SRC_LSB +: ADDR_W]), .ptr_o(bus.next_source));
  dma_wrap_ptr #(.W(ADDR_W), .LO(0), .HI(MEM_TOP), .RST(0)) u_dst (
    .clock(clock), .rst_n(rst_n), .ld_i(accept), .en_i(step_dst),
    .val_i(bus.instr[DST_LSB +: ADDR_W]), .ptr_o(bus.next_destination));
  dma_wrap_ptr #(.W(ADDR_W), .LO(FE_BASE), .HI(FE_TOP), .RST(FE_BASE)) u_fe (
    .clock(clock), .rst_n(rst_n), .ld_i(1'b0), .en_i(fe_step),
    .val_i('0), .ptr_o(bus.firstempty));
endmodule
